fc_layer_sequencer: RTL and testbench
=====================================

Name: fc_layer_sequencer

Overview:
- Control FSM that time-shares one K-lane MAC/accumulate engine between the FC1 (200->100, ReLU) and FC2 (100->3, linear) head layers of the BiLSTM localizer.
- Walks neurons and K-wide input tiles, issues weight/input tile addresses, clears and closes the accumulator, and sequences writeback.
- Drops the per-layer fixed start->done chaining in favour of one arbitrated engine and a single start/done handshake.

Parameters:
- IN_DIM_200, 200, FC1 input length
- OUT_DIM_100, 100, FC1 neurons (= FC2 input length)
- IN_DIM_100, 100, FC2 input length
- OUT_DIM_3, 3, FC2 neurons
- K, 4, MAC lanes / elements per tile
- ADDR_WIDTH, 16, width of address outputs

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a full FC1->FC2 pass; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE exits
- done_fc1  out  1  one-cycle pulse when the last FC1 writeback is accepted
- done  out  1  one-cycle pulse in DONE state
- layer_sel  out  1  0 = FC1, 1 = FC2
- neuron_idx  out  ADDR_WIDTH  current output neuron
- tile_idx  out  ADDR_WIDTH  current input tile (input elements tile_idx*K .. +K-1)
- w_addr  out  ADDR_WIDTH  weight word address = neuron_idx*TILES + tile_idx, per layer, from 0
- lane_mask  out  K  valid lanes of the current tile (all ones unless final partial tile)
- acc_clr  out  1  clear accumulator, CLR state only
- mac_valid  out  1  tile request valid
- mac_ready  in  1  engine accepts tile
- acc_last  out  1  qualifies the final tile of a neuron (with mac_valid)
- wb_valid  out  1  accumulated neuron ready for bias/activation/writeback
- wb_ready  in  1  writeback accepted
- relu_en  out  1  = ~layer_sel

Behaviour:
- TILES = ceil(IN/K): FC1 = 50, FC2 = 25.
- Final-tile lane_mask has (IN mod K) low bits set when IN mod K != 0.
- Reset (rst low, async): state IDLE. All outputs 0 except lane_mask = all ones. Counters and layer_sel = 0.
- Mid-operation reset aborts immediately, with no done or done_fc1 pulse.
- States:
  - IDLE: start=1 -> CLR with layer_sel=0, neuron_idx=0, tile_idx=0.
  - CLR: acc_clr=1 for exactly 1 cycle -> MAC.
  - MAC: mac_valid=1. On mac_valid&&mac_ready: if tile_idx==TILES-1 -> WB, else tile_idx++.
    - Address outputs are held stable while mac_ready=0.
    - acc_last = (tile_idx==TILES-1).
  - WB: wb_valid=1, held until wb_ready. On acceptance:
    - If neuron_idx < OUT-1: neuron_idx++, tile_idx=0 -> CLR.
    - Else if layer_sel=0: pulse done_fc1, set layer_sel=1, neuron_idx=0, tile_idx=0 -> CLR.
    - Else -> DONE.
  - DONE: done=1 for 1 cycle, busy still 1 -> IDLE (busy 0 next cycle).
- start while not in IDLE is ignored, not queued. start held high re-triggers on the cycle after DONE returns to IDLE.
- mac_valid, acc_clr and wb_valid are mutually exclusive.
- w_addr is computed registered or combinationally from the counters. It must be valid in the same cycle as mac_valid.
- Latency with mac_ready=wb_ready=1:
  - Per neuron = 1 (CLR) + TILES (MAC) + 1 (WB).
  - FC1 total = 5200 cycles; FC2 total = 81 cycles.
  - done is high in the 5282nd cycle after the edge that samples start.
  - done_fc1 is high in the 5200th cycle.
- Backpressure stalls only extend the state in which they occur. No request is dropped or duplicated.

Test Plan:
- Reset then start pulse, ready tied high:
  - done_fc1 at +5200 cycles, done at +5282.
  - Exactly 5000 FC1 and 75 FC2 mac handshakes.
  - 103 wb handshakes.
  - 103 acc_clr pulses.
- Address sweep:
  - First FC1 neuron gives w_addr 0..49 with acc_last only at tile 49.
  - FC2 neuron 2 gives w_addr 50..74.
  - relu_en=1 in FC1, 0 in FC2.
- Random mac_ready/wb_ready (50% duty): outputs stable during stalls, handshake counts as in the first test, done asserted once.
- start pulses while busy at cycles 10 and 3000: ignored, single done. start held high continuously: new pass begins the cycle after DONE.
- rst asserted in FC2 MAC state (neuron 1, tile 7):
  - Outputs zero asynchronously, no done pulse.
  - After release, a new start gives a clean full pass.
- Parameter override IN_DIM_200=10, K=4: TILES=3, final-tile lane_mask=4'b0011, all other tiles 4'b1111.

Source files
------------

// File: rtl/fc_layer_sequencer.sv
// ============================================================================
// Module   : fc_layer_sequencer
// Brief    : Shares one K-lane MAC engine between FC1 (ReLU) and FC2 (linear),
//            walking neurons and K-wide input tiles with tile/writeback handshakes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_layer_sequencer #(
    parameter int IN_DIM_200 = 200,
    parameter int OUT_DIM_100 = 100,
    parameter int IN_DIM_100 = 100,
    parameter int OUT_DIM_3 = 3,
    parameter int K = 4,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done_fc1,
    output logic                  done,
    output logic                  layer_sel,
    output logic [ADDR_WIDTH-1:0] neuron_idx,
    output logic [ADDR_WIDTH-1:0] tile_idx,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [K-1:0]          lane_mask,
    output logic                  acc_clr,
    output logic                  mac_valid,
    input  logic                  mac_ready,
    output logic                  acc_last,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic                  relu_en
);

    localparam int c_TILES_FC1 = (IN_DIM_200 + K - 1) / K;
    localparam int c_TILES_FC2 = (IN_DIM_100 + K - 1) / K;
    localparam int c_REM_FC1   = IN_DIM_200 % K;
    localparam int c_REM_FC2   = IN_DIM_100 % K;

    localparam logic [K-1:0] c_MASK_ALL = {K{1'b1}};
    localparam logic [K-1:0] c_MASK_FC1 = (c_REM_FC1 == 0) ? c_MASK_ALL : K'((1 << c_REM_FC1) - 1);
    localparam logic [K-1:0] c_MASK_FC2 = (c_REM_FC2 == 0) ? c_MASK_ALL : K'((1 << c_REM_FC2) - 1);

    localparam logic [ADDR_WIDTH-1:0] c_TILES_FC1_A     = ADDR_WIDTH'(c_TILES_FC1);
    localparam logic [ADDR_WIDTH-1:0] c_TILES_FC2_A     = ADDR_WIDTH'(c_TILES_FC2);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_TILE_FC1   = ADDR_WIDTH'(c_TILES_FC1 - 1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_TILE_FC2   = ADDR_WIDTH'(c_TILES_FC2 - 1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_NEURON_FC1 = ADDR_WIDTH'(OUT_DIM_100 - 1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_NEURON_FC2 = ADDR_WIDTH'(OUT_DIM_3 - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_MAC  = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                  r_state;
    logic                    r_layer_sel;
    logic [ADDR_WIDTH-1:0]   r_neuron_idx;
    logic [ADDR_WIDTH-1:0]   r_tile_idx;

    logic [ADDR_WIDTH-1:0]   w_tiles;
    logic                    w_is_last_tile;
    logic                    w_is_last_neuron;
    logic [K-1:0]            w_partial_mask;

    assign w_tiles          = r_layer_sel ? c_TILES_FC2_A : c_TILES_FC1_A;
    assign w_is_last_tile   = (r_tile_idx == (r_layer_sel ? c_LAST_TILE_FC2 : c_LAST_TILE_FC1));
    assign w_is_last_neuron = (r_neuron_idx == (r_layer_sel ? c_LAST_NEURON_FC2 : c_LAST_NEURON_FC1));
    assign w_partial_mask   = r_layer_sel ? c_MASK_FC2 : c_MASK_FC1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_layer_sel  <= 1'b0;
            r_neuron_idx <= '0;
            r_tile_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_CLR;
                        r_layer_sel  <= 1'b0;
                        r_neuron_idx <= '0;
                        r_tile_idx   <= '0;
                    end
                end
                S_CLR: r_state <= S_MAC;
                S_MAC: begin
                    if (mac_ready) begin
                        if (w_is_last_tile) begin
                            r_state <= S_WB;
                        end else begin
                            r_tile_idx <= r_tile_idx + 1'b1;
                        end
                    end
                end
                S_WB: begin
                    if (wb_ready) begin
                        r_tile_idx <= '0;
                        if (!w_is_last_neuron) begin
                            r_neuron_idx <= r_neuron_idx + 1'b1;
                            r_state      <= S_CLR;
                        end else if (!r_layer_sel) begin
                            // FC1 complete: hand the engine straight to FC2
                            r_layer_sel  <= 1'b1;
                            r_neuron_idx <= '0;
                            r_state      <= S_CLR;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state      <= S_IDLE;
                    r_layer_sel  <= 1'b0;
                    r_neuron_idx <= '0;
                    r_tile_idx   <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign acc_clr    = (r_state == S_CLR);
    assign mac_valid  = (r_state == S_MAC);
    assign wb_valid   = (r_state == S_WB);
    assign done       = (r_state == S_DONE);
    assign acc_last   = mac_valid && w_is_last_tile;
    // Pulses on the accepting cycle itself so it lines up with the final FC1 writeback
    assign done_fc1   = wb_valid && wb_ready && w_is_last_neuron && !r_layer_sel;
    assign layer_sel  = r_layer_sel;
    assign neuron_idx = r_neuron_idx;
    assign tile_idx   = r_tile_idx;
    assign w_addr     = r_neuron_idx * w_tiles + r_tile_idx;
    assign lane_mask  = (mac_valid && w_is_last_tile) ? w_partial_mask : c_MASK_ALL;
    assign relu_en    = busy && !r_layer_sel;

endmodule

`default_nettype wire

// File: tb/tb_fc_layer_sequencer.sv
// ============================================================================
// Module   : tb_fc_layer_sequencer
// Brief    : Directed self-checking bench for fc_layer_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_layer_sequencer;

    logic        clk;
    logic        rst;
    logic        start, mac_ready, wb_ready;
    logic        busy, done_fc1, done, layer_sel, acc_clr, mac_valid, acc_last, wb_valid, relu_en;
    logic [15:0] neuron_idx, tile_idx, w_addr;
    logic [3:0]  lane_mask;

    logic        start2;
    logic        busy2, done_fc1_2, done2, layer_sel2, acc_clr2, mac_valid2, acc_last2, wb_valid2, relu_en2;
    logic [15:0] neuron_idx2, tile_idx2, w_addr2;
    logic [3:0]  lane_mask2;

    fc_layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done_fc1(done_fc1), .done(done),
        .layer_sel(layer_sel), .neuron_idx(neuron_idx), .tile_idx(tile_idx), .w_addr(w_addr),
        .lane_mask(lane_mask), .acc_clr(acc_clr), .mac_valid(mac_valid), .mac_ready(mac_ready),
        .acc_last(acc_last), .wb_valid(wb_valid), .wb_ready(wb_ready), .relu_en(relu_en)
    );

    fc_layer_sequencer #(.IN_DIM_200(10), .K(4)) dut_small (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done_fc1(done_fc1_2), .done(done2),
        .layer_sel(layer_sel2), .neuron_idx(neuron_idx2), .tile_idx(tile_idx2), .w_addr(w_addr2),
        .lane_mask(lane_mask2), .acc_clr(acc_clr2), .mac_valid(mac_valid2), .mac_ready(1'b1),
        .acc_last(acc_last2), .wb_valid(wb_valid2), .wb_ready(1'b1), .relu_en(relu_en2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Negedge monitor: handshake counts, stall stability, exclusivity, address sweep
    int cyc = 0, rise_cyc = 0, done_cyc = 0, fc1_cyc = 0;
    int mac1 = 0, mac2 = 0, wb_cnt = 0, clr_cnt = 0, done_cnt = 0, fc1_cnt = 0;
    int stall_bad = 0, excl_bad = 0, addr_bad = 0, last_bad = 0, relu_bad = 0, mask_bad = 0;
    int exp_tiles;
    logic        p_mv = 0, p_mr = 0, p_wv = 0, p_wr = 0, p_busy = 0, p_layer = 0, p_last = 0;
    logic [15:0] p_addr = 0, p_tile = 0, p_neuron = 0;
    logic [3:0]  p_mask = 0;
    int a1[50];
    bit l1[50];
    int a2[25];

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            p_mv = 0; p_wv = 0; p_busy = 0;
        end else begin
            if (busy && !p_busy) rise_cyc = cyc;
            if (p_mv && !p_mr && !(mac_valid && w_addr == p_addr && tile_idx == p_tile &&
                neuron_idx == p_neuron && layer_sel == p_layer && acc_last == p_last && lane_mask == p_mask))
                stall_bad++;
            if (p_wv && !p_wr && !(wb_valid && neuron_idx == p_neuron && layer_sel == p_layer))
                stall_bad++;
            if (int'(mac_valid) + int'(acc_clr) + int'(wb_valid) > 1) excl_bad++;
            if (acc_clr) clr_cnt++;
            if (wb_valid && wb_ready) wb_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (done_fc1) begin fc1_cnt++; fc1_cyc = cyc; end
            if (mac_valid && mac_ready) begin
                exp_tiles = layer_sel ? 25 : 50;
                if (layer_sel) mac2++; else mac1++;
                if (int'(w_addr) != int'(neuron_idx) * exp_tiles + int'(tile_idx)) addr_bad++;
                if (acc_last != (int'(tile_idx) == exp_tiles - 1)) last_bad++;
                if (relu_en != !layer_sel) relu_bad++;
                if (lane_mask != 4'hF) mask_bad++;
                if (!layer_sel && neuron_idx == 0 && tile_idx < 50) begin
                    a1[int'(tile_idx)] = int'(w_addr);
                    l1[int'(tile_idx)] = acc_last;
                end
                if (layer_sel && neuron_idx == 2 && tile_idx < 25) a2[int'(tile_idx)] = int'(w_addr);
            end
            p_mv = mac_valid; p_mr = mac_ready; p_wv = wb_valid; p_wr = wb_ready;
            p_busy = busy; p_layer = layer_sel; p_last = acc_last;
            p_addr = w_addr; p_tile = tile_idx; p_neuron = neuron_idx; p_mask = lane_mask;
        end
    end

    int s_mac1, s_mac2, s_wb, s_clr, s_done, s_fc1, s_stall, s_excl, s_addr, s_last, s_relu, s_mask;

    task automatic snapshot();
        s_mac1 = mac1; s_mac2 = mac2; s_wb = wb_cnt; s_clr = clr_cnt; s_done = done_cnt; s_fc1 = fc1_cnt;
        s_stall = stall_bad; s_excl = excl_bad; s_addr = addr_bad; s_last = last_bad;
        s_relu = relu_bad; s_mask = mask_bad;
    endtask

    task automatic check_pass(input string tag);
        chk({tag, "_mac_fc1"}, mac1 - s_mac1, 5000);
        chk({tag, "_mac_fc2"}, mac2 - s_mac2, 75);
        chk({tag, "_wb_hs"}, wb_cnt - s_wb, 103);
        chk({tag, "_acc_clr"}, clr_cnt - s_clr, 103);
        chk({tag, "_done_cnt"}, done_cnt - s_done, 1);
        chk({tag, "_done_fc1_cnt"}, fc1_cnt - s_fc1, 1);
        chk({tag, "_stall"}, stall_bad - s_stall, 0);
        chk({tag, "_excl"}, excl_bad - s_excl, 0);
        chk({tag, "_addr"}, addr_bad - s_addr, 0);
        chk({tag, "_acc_last"}, last_bad - s_last, 0);
        chk({tag, "_relu"}, relu_bad - s_relu, 0);
        chk({tag, "_mask"}, mask_bad - s_mask, 0);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit rnd);
        int base;
        int i;
        base = done_cnt;
        i = 0;
        while (done_cnt == base && i < budget) begin
            if (rnd) begin
                mac_ready = 1'($urandom_range(1));
                wb_ready  = 1'($urandom_range(1));
            end
            tick(1);
            i++;
        end
        mac_ready = 1'b1;
        wb_ready  = 1'b1;
        chk({tag, "_done_seen"}, done_cnt != base, 1);
    endtask

    logic [3:0] m2[3];
    bit         l2[3];
    int         wa2, d2, f2, clr2, wbc2, relu2;
    int         errs;
    bit         found;

    initial begin
        rst = 1'b0; start = 1'b0; start2 = 1'b0; mac_ready = 1'b1; wb_ready = 1'b1;
        m2[0] = 0; m2[1] = 0; m2[2] = 0; l2[0] = 0; l2[1] = 0; l2[2] = 0;
        wa2 = -1; d2 = -1; f2 = -1; clr2 = 0; wbc2 = 0; relu2 = 0;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_done_fc1", done_fc1, 0);
        chk("rst_mac_valid", mac_valid, 0);
        chk("rst_acc_clr", acc_clr, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_layer", layer_sel, 0);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_lane_mask", lane_mask, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        tick(2);

        // Small-parameter instance: 10 inputs over 4 lanes -> 3 tiles, last one partial
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        for (int k = 1; k <= 700; k++) begin
            if (acc_clr2) clr2++;
            if (wb_valid2) wbc2++;
            if (done_fc1_2) f2 = k;
            if (mac_valid2 && !layer_sel2 && neuron_idx2 == 0 && tile_idx2 < 3) begin
                m2[int'(tile_idx2)] = lane_mask2;
                l2[int'(tile_idx2)] = acc_last2;
                if (relu_en2) relu2++;
            end
            if (mac_valid2 && !layer_sel2 && neuron_idx2 == 1 && tile_idx2 == 0) wa2 = int'(w_addr2);
            if (done2) begin
                d2 = k;
                break;
            end
            tick(1);
        end
        chk("small_mask_t0", m2[0], 4'b1111);
        chk("small_mask_t1", m2[1], 4'b1111);
        chk("small_mask_t2", m2[2], 4'b0011);
        chk("small_last_t1", l2[1], 0);
        chk("small_last_t2", l2[2], 1);
        chk("small_relu_fc1", relu2, 3);
        chk("small_w_addr_n1", wa2, 3);
        chk("small_done_fc1_cycle", f2, 500);
        chk("small_done_cycle", d2, 582);
        chk("small_acc_clr", clr2, 103);
        chk("small_wb", wbc2, 103);
        tick(1);
        chk("small_busy_after", busy2, 0);

        // Full pass, both readies high
        snapshot();
        pulse_start();
        wait_done("t1", 6000, 1'b0);
        chk("t1_busy_after_done", busy, 0);
        chk("t1_done_cycle", done_cyc - rise_cyc + 1, 5282);
        chk("t1_fc1_cycle", fc1_cyc - rise_cyc + 1, 5200);
        check_pass("t1");
        errs = 0;
        for (int t = 0; t < 50; t++) if (a1[t] != t || l1[t] != (t == 49)) errs++;
        chk("sweep_fc1_n0", errs, 0);
        errs = 0;
        for (int t = 0; t < 25; t++) if (a2[t] != 50 + t) errs++;
        chk("sweep_fc2_n2", errs, 0);

        // Random backpressure on both handshakes
        snapshot();
        pulse_start();
        wait_done("t2", 30000, 1'b1);
        tick(20);
        check_pass("t2");

        // start pulses while busy must be ignored
        snapshot();
        pulse_start();
        tick(9);
        pulse_start();
        tick(2989);
        pulse_start();
        wait_done("t3", 6000, 1'b0);
        tick(10);
        chk("t3_idle_after", busy, 0);
        check_pass("t3");

        // start held high: re-trigger one cycle after DONE returns to IDLE
        snapshot();
        start = 1'b1;
        wait_done("t4", 6000, 1'b0);
        chk("t4_idle_gap_busy", busy, 0);
        tick(1);
        chk("t4_retrigger_busy", busy, 1);
        chk("t4_retrigger_clr", acc_clr, 1);
        start = 1'b0;

        // Abort in FC2 neuron 1 tile 7
        found = 0;
        for (int i = 0; i < 6000; i++) begin
            if (mac_valid && layer_sel && neuron_idx == 1 && tile_idx == 7) begin
                found = 1;
                break;
            end
            tick(1);
        end
        chk("t5_reach_abort_point", found, 1);
        snapshot();
        #2;
        rst = 1'b0;
        #1;
        chk("t5_async_busy", busy, 0);
        chk("t5_async_mac_valid", mac_valid, 0);
        chk("t5_async_layer", layer_sel, 0);
        chk("t5_async_neuron", neuron_idx, 0);
        chk("t5_async_tile", tile_idx, 0);
        chk("t5_async_w_addr", w_addr, 0);
        chk("t5_async_lane_mask", lane_mask, 4'hF);
        tick(4);
        chk("t5_no_done", done_cnt - s_done, 0);
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        snapshot();
        pulse_start();
        wait_done("t5", 6000, 1'b0);
        chk("t5_done_cycle", done_cyc - rise_cyc + 1, 5282);
        chk("t5_fc1_cycle", fc1_cyc - rise_cyc + 1, 5200);
        check_pass("t5");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
